// File: rtl/udma_ptp_ts_tx.sv
// udma_ptp_ts_tx: packs 32-bit uDMA TX words, three at a time, into 96-bit
// AXI-Stream beats for the ethernet MAC TX path. The first word lands in the
// top lane [95:64]. tlast comes from a programmable beats-per-frame counter,
// and a flush request emits a partial group padded with zeros (tuser=1).
// Optional build macro UDMA_PTP_TX_STATS_EN adds a saturating sent-beat
// counter on sent_beats_o; without it, sent_beats_o is tied to zero.
module udma_ptp_ts_tx #(
    parameter int FRAME_CNT_W = 8,
    parameter int STAT_CNT_W  = 16
) (
    input  logic                   sys_clk_i,
    input  logic                   rstn_i,
    input  logic                   cfg_en_i,
    input  logic                   cfg_clr_i,
    input  logic [FRAME_CNT_W-1:0] cfg_frame_beats_i,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic [1:0]             data_tx_datasize_o,
    input  logic [31:0]            data_tx_i,
    input  logic                   data_tx_valid_i,
    output logic                   data_tx_ready_o,
    output logic [95:0]            tx_axis_tdata,
    output logic                   tx_axis_tvalid,
    input  logic                   tx_axis_tready,
    output logic                   tx_axis_tlast,
    output logic                   tx_axis_tuser,
    output logic [STAT_CNT_W-1:0]  sent_beats_o
);

    localparam logic [1:0] W0 = 2'd0;
    localparam logic [1:0] W1 = 2'd1;
    localparam logic [1:0] W2 = 2'd2;

    logic [1:0]             state;
    logic [31:0]            w0;
    logic [31:0]            w1;
    logic [FRAME_CNT_W-1:0] beat_cnt;
    logic                   flush_ack;

    logic                   out_free;
    logic                   accept;
    logic                   flush_act;
    logic                   load_full;
    logic                   load_flush;
    logic                   flush_empty;
    logic                   load;
    logic                   last_calc;
    logic [FRAME_CNT_W-1:0] frame_last;
    logic [95:0]            load_data;

    assign data_tx_datasize_o = 2'b10;

    // The output slot can take a new beat when empty or draining this cycle.
    assign out_free        = ~tx_axis_tvalid | tx_axis_tready;
    assign data_tx_ready_o = cfg_en_i & ~cfg_clr_i & ~flush_i & ((state != W2) | out_free);
    assign accept          = data_tx_valid_i & data_tx_ready_o;

    // flush_ack remembers that the current request level was already served,
    // so a long-held flush_i yields a single flush_done_o pulse.
    assign flush_act   = flush_i & ~flush_ack & ~cfg_clr_i;
    assign load_full   = accept & (state == W2);
    assign load_flush  = flush_act & (state != W0) & out_free;
    assign flush_empty = flush_act & (state == W0);
    assign load        = load_full | load_flush;

    assign frame_last = cfg_frame_beats_i - FRAME_CNT_W'(1);
    assign last_calc  = (cfg_frame_beats_i != '0) & (beat_cnt == frame_last);

    // Assemble the beat: full group, or partial group with zeroed lower lanes.
    always_comb begin
        load_data = {w0, 64'h0};
        if (load_full) begin
            load_data = {w0, w1, data_tx_i};
        end else if (state == W2) begin
            load_data = {w0, w1, 32'h0};
        end
    end

    // Word buffer and fill-level state.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= W0;
            w0    <= '0;
            w1    <= '0;
        end else if (cfg_clr_i) begin
            state <= W0;
            w0    <= '0;
            w1    <= '0;
        end else if (load_flush) begin
            state <= W0;
        end else if (accept) begin
            case (state)
                W0: begin
                    w0    <= data_tx_i;
                    state <= W1;
                end
                W1: begin
                    w1    <= data_tx_i;
                    state <= W2;
                end
                default: state <= W0;
            endcase
        end
    end

    // AXIS output register: load wins over drain so beats run back to back.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_axis_tvalid <= 1'b0;
            tx_axis_tdata  <= '0;
            tx_axis_tlast  <= 1'b0;
            tx_axis_tuser  <= 1'b0;
        end else if (cfg_clr_i) begin
            tx_axis_tvalid <= 1'b0;
        end else if (load) begin
            tx_axis_tvalid <= 1'b1;
            tx_axis_tdata  <= load_data;
            tx_axis_tlast  <= load_flush | last_calc;
            tx_axis_tuser  <= load_flush;
        end else if (tx_axis_tready) begin
            tx_axis_tvalid <= 1'b0;
        end
    end

    // Beat position within the frame; a flush beat always closes the frame.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            beat_cnt <= '0;
        end else if (cfg_clr_i || load_flush) begin
            beat_cnt <= '0;
        end else if (load_full) begin
            beat_cnt <= last_calc ? '0 : beat_cnt + FRAME_CNT_W'(1);
        end
    end

    // Flush completion pulse and per-request acknowledge latch.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            flush_done_o <= 1'b0;
            flush_ack    <= 1'b0;
        end else begin
            flush_done_o <= load_flush | flush_empty;
            flush_ack    <= flush_i & (flush_ack | load_flush | flush_empty);
        end
    end

`ifdef UDMA_PTP_TX_STATS_EN
    // Saturating count of completed AXIS handshakes.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sent_beats_o <= '0;
        end else if (cfg_clr_i) begin
            sent_beats_o <= '0;
        end else if (tx_axis_tvalid && tx_axis_tready && !(&sent_beats_o)) begin
            sent_beats_o <= sent_beats_o + STAT_CNT_W'(1);
        end
    end
`else
    assign sent_beats_o = '0;
`endif

endmodule

// File: tb/tb_udma_ptp_ts_tx.sv
// Bench for udma_ptp_ts_tx: randomized words, a queue-based frame/packing
// model, and per-scenario tasks that compare observed beats inline.
module tb_udma_ptp_ts_tx;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        cfg_en = 1'b0;
    logic        cfg_clr = 1'b0;
    logic [7:0]  cfg_beats = 8'd0;
    logic        flush = 1'b0;
    logic        flush_done;
    logic [1:0]  datasize;
    logic [31:0] data_tx = 32'h0;
    logic        data_tx_valid = 1'b0;
    logic        data_tx_ready;
    logic [95:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
    logic        tuser;
    logic [15:0] sent_beats;

    udma_ptp_ts_tx #(.FRAME_CNT_W(8), .STAT_CNT_W(16)) dut (
        .sys_clk_i         (clk),
        .rstn_i            (rstn),
        .cfg_en_i          (cfg_en),
        .cfg_clr_i         (cfg_clr),
        .cfg_frame_beats_i (cfg_beats),
        .flush_i           (flush),
        .flush_done_o      (flush_done),
        .data_tx_datasize_o(datasize),
        .data_tx_i         (data_tx),
        .data_tx_valid_i   (data_tx_valid),
        .data_tx_ready_o   (data_tx_ready),
        .tx_axis_tdata     (tdata),
        .tx_axis_tvalid    (tvalid),
        .tx_axis_tready    (tready),
        .tx_axis_tlast     (tlast),
        .tx_axis_tuser     (tuser),
        .sent_beats_o      (sent_beats)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted words queue up; every third word forms a beat.
    // Frame position is tracked as an integer modulo the counter range.
    logic [31:0] pend[$];
    logic [97:0] expq[$];
    logic [97:0] obsq[$];
    int          mcnt = 0;

    function automatic void model_full_beat();
        bit lst;
        lst = (cfg_beats != 0) && (mcnt == int'(cfg_beats) - 1);
        expq.push_back({1'b0, lst, pend[0], pend[1], pend[2]});
        pend.delete();
        mcnt = lst ? 0 : (mcnt + 1) % 256;
    endfunction

    function automatic void model_flush();
        if (pend.size() == 1) begin
            expq.push_back({2'b11, pend[0], 64'h0});
            mcnt = 0;
        end else if (pend.size() == 2) begin
            expq.push_back({2'b11, pend[0], pend[1], 32'h0});
            mcnt = 0;
        end
        pend.delete();
    endfunction

    function automatic void model_clear();
        pend.delete();
        expq.delete();
        obsq.delete();
        mcnt = 0;
    endfunction

    always @(negedge clk) begin
        if (rstn && data_tx_valid && data_tx_ready) begin
            pend.push_back(data_tx);
            if (pend.size() == 3) model_full_beat();
        end
        if (rstn && tvalid && tready) obsq.push_back({tuser, tlast, tdata});
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit acc;
        int n;
        data_tx = w;
        data_tx_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = data_tx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        data_tx_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_word: word %h not accepted, required accept within 200 cycles", w);
        end
    endtask

    task automatic wait_obs(input int n);
        int k;
        k = 0;
        while (obsq.size() < n && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (obsq.size() < n) begin
            checks++; errors++;
            $display("FAIL wait_obs: got %0d beats, required %0d", obsq.size(), n);
        end
    endtask

    task automatic do_flush();
        bit seen;
        int k;
        flush = 1'b1;
        model_flush();
        seen = 1'b0;
        k = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            seen = flush_done;
            k++;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL flush_done: got no pulse, required pulse within 200 cycles");
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #1;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", tvalid); end
        checks++; if (tdata !== 96'h0) begin errors++; $display("FAIL reset_tdata: got %h required 0", tdata); end
        checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b required 0", tlast); end
        checks++; if (tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b required 0", tuser); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b required 0", flush_done); end
        checks++; if (sent_beats !== 16'h0) begin errors++; $display("FAIL reset_sent_beats: got %0d required 0", sent_beats); end
        checks++; if (datasize !== 2'b10) begin errors++; $display("FAIL datasize: got %b required 10", datasize); end
        idle(3);
        rstn = 1'b1;
        idle(1);
        @(negedge clk);
        checks++; if (data_tx_ready !== 1'b0) begin errors++; $display("FAIL ready_disabled: got %b required 0", data_tx_ready); end
        @(posedge clk); #1;
        cfg_en = 1'b1;
        @(negedge clk);
        checks++; if (data_tx_ready !== 1'b1) begin errors++; $display("FAIL ready_enabled: got %b required 1", data_tx_ready); end
        @(posedge clk); #1;
        model_clear();
    endtask

    task automatic test_basic();
        logic [31:0] w [6];
        w = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        cfg_beats = 8'd2;
        tready = 1'b1;
        for (int i = 0; i < 6; i++) send_word(w[i]);
        wait_obs(2);
        idle(2);
        checks++; if (obsq.size() != 2) begin errors++; $display("FAIL basic_count: got %0d beats required 2", obsq.size()); end
        if (obsq.size() >= 2) begin
            checks++; if (obsq[0] !== {2'b00, 96'h00000011_00000022_00000033}) begin errors++; $display("FAIL basic_beat1: got %h required %h", obsq[0], {2'b00, 96'h00000011_00000022_00000033}); end
            checks++; if (obsq[1] !== {2'b01, 96'h00000044_00000055_00000066}) begin errors++; $display("FAIL basic_beat2: got %h required %h", obsq[1], {2'b01, 96'h00000044_00000055_00000066}); end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] w [6];
        logic [97:0] held;
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        tready = 1'b0;
        for (int i = 0; i < 5; i++) send_word(w[i]);
        idle(1);
        held = expq[0];
        data_tx = w[5];
        data_tx_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (data_tx_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d: got %b required 0", c, data_tx_ready); end
            checks++; if ({tvalid, tuser, tlast, tdata} !== {1'b1, held}) begin errors++; $display("FAIL bp_hold_c%0d: got %b %h required 1 %h", c, tvalid, {tuser, tlast, tdata}, held); end
            @(posedge clk); #1;
        end
        tready = 1'b1;
        send_word(w[5]);
        @(negedge clk);
        checks++; if (tvalid !== 1'b1 || tdata !== {w[3], w[4], w[5]}) begin errors++; $display("FAIL bp_back_to_back: got %b %h required 1 %h", tvalid, tdata, {w[3], w[4], w[5]}); end
        @(posedge clk); #1;
        wait_obs(2);
        idle(2);
        checks++; if (obsq.size() != 2 || expq.size() != 2) begin errors++; $display("FAIL bp_count: got %0d beats required 2", obsq.size()); end
        if (obsq.size() >= 2) begin
            checks++; if (obsq[0] !== {2'b00, w[0], w[1], w[2]}) begin errors++; $display("FAIL bp_beat1: got %h required %h", obsq[0], {2'b00, w[0], w[1], w[2]}); end
            checks++; if (obsq[1] !== {2'b01, w[3], w[4], w[5]}) begin errors++; $display("FAIL bp_beat2: got %h required %h", obsq[1], {2'b01, w[3], w[4], w[5]}); end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_flush();
        int pulses;
        bit seen;
        int k;
        int nb;
        logic [31:0] w [3];
        cfg_beats = 8'd2;
        tready = 1'b1;
        send_word(32'hAA);
        send_word(32'hBB);
        flush = 1'b1;
        model_flush();
        pulses = 0; seen = 1'b0; k = 0;
        @(negedge clk);
        checks++; if (data_tx_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b required 0", data_tx_ready); end
        if (flush_done) begin pulses++; seen = 1'b1; end
        while (!seen && k < 100) begin
            @(negedge clk);
            if (flush_done) begin pulses++; seen = 1'b1; end
            k++;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (flush_done) pulses++;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        idle(2);
        checks++; if (pulses != 1) begin errors++; $display("FAIL flush_pulses: got %0d required 1", pulses); end
        wait_obs(1);
        if (obsq.size() >= 1) begin
            checks++; if (obsq[0] !== {2'b11, 96'h000000AA_000000BB_00000000}) begin errors++; $display("FAIL flush_beat: got %h required %h", obsq[0], {2'b11, 96'h000000AA_000000BB_00000000}); end
        end
        obsq.delete(); expq.delete();
        for (int i = 0; i < 3; i++) begin w[i] = $urandom; send_word(w[i]); end
        wait_obs(1);
        if (obsq.size() >= 1) begin
            checks++; if (obsq[0] !== {2'b00, w[0], w[1], w[2]}) begin errors++; $display("FAIL flush_cnt_reset: got %h required %h", obsq[0], {2'b00, w[0], w[1], w[2]}); end
        end
        idle(2);
        nb = obsq.size();
        do_flush();
        idle(4);
        checks++; if (obsq.size() != nb) begin errors++; $display("FAIL flush_empty_nobeat: got %0d beats required %0d", obsq.size(), nb); end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_no_tlast();
        cfg_beats = 8'd0;
        tready = 1'b1;
        for (int i = 0; i < 9; i++) send_word($urandom);
        wait_obs(3);
        idle(2);
        checks++; if (obsq.size() != 3 || expq.size() != 3) begin errors++; $display("FAIL nolast_count: got %0d beats required 3", obsq.size()); end
        for (int i = 0; i < 3 && i < obsq.size() && i < expq.size(); i++) begin
            checks++; if (obsq[i] !== expq[i] || obsq[i][96] !== 1'b0) begin errors++; $display("FAIL nolast_beat%0d: got %h required %h", i, obsq[i], expq[i]); end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_clear();
        cfg_beats = 8'd2;
        tready = 1'b0;
        for (int i = 0; i < 5; i++) send_word($urandom);
        idle(1);
        @(negedge clk);
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL clr_pending: got tvalid %b required 1", tvalid); end
        @(posedge clk); #1;
        cfg_clr = 1'b1;
        model_clear();
        @(posedge clk); #1;
        cfg_clr = 1'b0;
        @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL clr_tvalid: got %b required 0", tvalid); end
        checks++; if (data_tx_ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b required 1", data_tx_ready); end
        @(posedge clk); #1;
        tready = 1'b1;
        for (int i = 0; i < 6; i++) send_word($urandom);
        wait_obs(2);
        idle(2);
        checks++; if (obsq.size() != 2 || expq.size() != 2) begin errors++; $display("FAIL clr_count: got %0d beats required 2", obsq.size()); end
        if (obsq.size() >= 2 && expq.size() >= 2) begin
            checks++; if (obsq[0] !== expq[0] || obsq[0][96] !== 1'b0) begin errors++; $display("FAIL clr_beat1: got %h required %h", obsq[0], expq[0]); end
            checks++; if (obsq[1] !== expq[1] || obsq[1][96] !== 1'b1) begin errors++; $display("FAIL clr_beat2: got %h required %h", obsq[1], expq[1]); end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_stats();
        logic [15:0] want;
        cfg_clr = 1'b1;
        model_clear();
        @(posedge clk); #1;
        cfg_clr = 1'b0;
        cfg_beats = 8'd3;
        tready = 1'b1;
        for (int i = 0; i < 15; i++) send_word($urandom);
        wait_obs(5);
        idle(2);
`ifdef UDMA_PTP_TX_STATS_EN
        want = 16'd5;
`else
        want = 16'd0;
`endif
        checks++; if (sent_beats !== want) begin errors++; $display("FAIL stats_count: got %0d required %0d", sent_beats, want); end
        for (int i = 0; i < 5 && i < obsq.size() && i < expq.size(); i++) begin
            checks++; if (obsq[i] !== expq[i]) begin errors++; $display("FAIL stats_beat%0d: got %h required %h", i, obsq[i], expq[i]); end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_back_to_back();
        bit done;
        done = 1'b0;
        cfg_beats = 8'($urandom_range(1, 5));
        fork
            begin
                for (int i = 0; i < 30; i++) send_word($urandom);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        tready = 1'b1;
        wait_obs(10);
        idle(2);
        checks++; if (obsq.size() != 10 || expq.size() != 10) begin errors++; $display("FAIL b2b_count: got %0d beats required 10", obsq.size()); end
        for (int i = 0; i < 10 && i < obsq.size() && i < expq.size(); i++) begin
            checks++; if (obsq[i] !== expq[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h required %h", i, obsq[i], expq[i]); end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_async_reset();
        tready = 1'b0;
        send_word($urandom);
        do_flush();
        @(negedge clk);
        checks++; if ({tvalid, tlast, tuser} !== 3'b111) begin errors++; $display("FAIL areset_pre: got %b required 111", {tvalid, tlast, tuser}); end
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++; if ({tvalid, tlast, tuser, flush_done} !== 4'b0000) begin errors++; $display("FAIL areset_ctrl: got %b required 0000", {tvalid, tlast, tuser, flush_done}); end
        checks++; if (tdata !== 96'h0) begin errors++; $display("FAIL areset_tdata: got %h required 0", tdata); end
        checks++; if (sent_beats !== 16'h0) begin errors++; $display("FAIL areset_sent: got %0d required 0", sent_beats); end
        model_clear();
        idle(2);
        rstn = 1'b1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_no_tlast();
        test_clear();
        test_stats();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udma_ptp_ts_tx.md
Name: udma_ptp_ts_tx

Overview:
TX-direction companion of the PTP timestamp RX bridge. It accepts 32-bit words from the uDMA TX channel and packs each group of three into one 96-bit AXI-Stream beat for the ethernet MAC timestamp/TX interface. It generates tlast from a programmable frame length and flushes a partial group with zero padding on request. Single clock domain (sys_clk_i); any clock-domain crossing to clk_eth is done by an external dc fifo on the AXIS side.

Parameters:
FRAME_CNT_W, 8, width of the frame-length configuration and the beat counter
STAT_CNT_W, 16, width of the optional sent-beat statistics counter

Ports:
sys_clk_i  input  1  system clock
rstn_i  input  1  asynchronous active-low reset
cfg_en_i  input  1  packer enable; when low, no new uDMA words are accepted
cfg_clr_i  input  1  synchronous clear of packer, output register and beat counter
cfg_frame_beats_i  input  FRAME_CNT_W  96-bit beats per frame; 0 disables counter-based tlast
flush_i  input  1  level request: emit the partial group padded with zeros
flush_done_o  output  1  one-cycle pulse when a flush beat is loaded or a flush is dropped as empty
data_tx_datasize_o  output  2  constant 2'b10 (32-bit words)
data_tx_i  input  32  uDMA TX data
data_tx_valid_i  input  1  uDMA TX valid
data_tx_ready_o  output  1  uDMA TX ready
tx_axis_tdata  output  96  packed beat
tx_axis_tvalid  output  1  beat valid
tx_axis_tready  input  1  downstream ready
tx_axis_tlast  output  1  last beat of frame
tx_axis_tuser  output  1  beat contains zero padding (flush)
sent_beats_o  output  STAT_CNT_W  sent-beat count (only with UDMA_PTP_TX_STATS_EN, otherwise tied to 0)

Behaviour:
- Reset (async, rstn_i low): state W0, word buffer 0, tx_axis_tvalid/tlast/tuser 0, tdata 0, beat counter 0, flush_done_o 0, sent_beats_o 0.
- Word order matches the RX bridge: first word goes to [95:64], second to [63:32], third to [31:0].
- States: W0 (empty), W1 (one word held), W2 (two words held). A word is accepted when data_tx_valid_i & data_tx_ready_o.
- out_free = ~tx_axis_tvalid | tx_axis_tready.
- data_tx_ready_o = cfg_en_i & ~cfg_clr_i & ~flush_i & (state != W2 | out_free).
- Accept in W0 -> W1; accept in W1 -> W2.
- Accept in W2 -> W0. The output register loads {w0, w1, data_tx_i} in the same cycle; tvalid=1 on the next edge. Latency is one cycle from the third accept to tvalid.
- Output register holds tdata, tlast and tuser stable while tvalid & ~tready.
- Output register clears tvalid on handshake unless it is reloaded in the same cycle. This gives back-to-back beats at full rate with no bubble.
- tlast = (cfg_frame_beats_i != 0) & (beat_cnt == cfg_frame_beats_i - 1), evaluated at load time.
- beat_cnt increments on every load and wraps to 0 after the tlast beat. If cfg_frame_beats_i is changed mid-frame and beat_cnt >= the new value, the counter wraps at its natural width without asserting tlast; software must clear before changing the value.
- Flush: while flush_i is high, uDMA words are not accepted.
  - In W1 or W2 with out_free: load the partial group, zero-filling the missing lower words. tuser=1, tlast=1, beat_cnt reset to 0, state W0, flush_done_o pulses.
  - In W0: no beat is emitted and flush_done_o pulses.
  - If out_free=0, the flush waits.
  - flush_done_o pulses once per rising request; the requester must drop flush_i after flush_done_o.
- cfg_clr_i (priority over everything except reset): next edge forces state W0, tvalid=0, beat_cnt=0. Buffered words and the pending beat are discarded. This intentionally violates the AXIS hold rule, so it is used only with the MAC TX disabled.
- cfg_en_i low does not stop output draining or flush.

Optional Feature:
UDMA_PTP_TX_STATS_EN: when defined, sent_beats_o counts AXIS handshakes (tvalid & tready). It saturates at all-ones and is cleared by reset or cfg_clr_i. When undefined, the counter logic is absent and sent_beats_o is constant 0.

Test Plan:
- cfg_frame_beats_i=2, tready=1, words 0x11,0x22,0x33,0x44,0x55,0x66 -> beat1 tdata=0x00000011_00000022_00000033 tlast=0; beat2 0x44_55_66 tlast=1; tuser=0 for both.
- tready=0 after first beat, stream 6 more words -> data_tx_ready_o drops in W2. The beat stays stable; on tready=1, the remaining beats follow with no lost or duplicated word.
- Accept 0xAA,0xBB, then flush_i=1 -> beat 0x000000AA_000000BB_00000000 with tuser=1 and tlast=1; flush_done_o pulses; beat_cnt=0. Flush in W0 -> no beat, flush_done_o pulses.
- cfg_frame_beats_i=0, 9 words -> 3 beats, tlast never asserted.
- Load 2 words plus a pending beat with tready=0, pulse cfg_clr_i -> tvalid=0 and state W0 next cycle. The next 3 words form a clean beat with tlast computed from beat_cnt=0.
- Stats enabled: 5 handshakes -> sent_beats_o=5. Assert rstn_i low mid-beat -> all outputs return to reset values asynchronously.
